// File: rtl/instr_mem_pipe_if.sv
// Fetch, response and program-load signals between the fetch-PC stage
// and the instruction memory. master = fetch side, slave = memory.
interface instr_mem_pipe_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_instr;
    logic [1:0]        resp_err;
    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic [15:0]       err_count;

    modport master (
        output req_valid, req_addr, resp_ready, ld_en, ld_addr, ld_data,
        input  req_ready, resp_valid, resp_instr, resp_err, err_count
    );

    modport slave (
        input  req_valid, req_addr, resp_ready, ld_en, ld_addr, ld_data,
        output req_ready, resp_valid, resp_instr, resp_err, err_count
    );
endinterface

// File: rtl/instr_mem_pipe.sv
// Instruction memory with a valid/ready fetch port, one-cycle registered
// read into a single stallable output register, fault flagging for
// misaligned / out-of-range fetches and a side port for program download.
module instr_mem_pipe #(
    parameter int                 DATA_W    = 32,
    parameter int                 DEPTH     = 256,
    parameter int                 ADDR_W    = 32,
    parameter logic [DATA_W-1:0]  NOP_INSTR = 32'h00000013,
    parameter string              INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst,
    instr_mem_pipe_if.slave   bus
);
    localparam int OFF   = $clog2(DATA_W / 8);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'((64'd1 << OFF) - 64'd1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    // NOTE: the array has no reset; clearing a RAM would need a per-word
    // reset network and a program image must survive a pipeline reset.
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_instr_q, resp_instr_d;
    logic [1:0]        resp_err_q,   resp_err_d;
    logic [15:0]       err_count_q,  err_count_d;

    logic [ADDR_W-1:0] req_idx, ld_idx;
    logic              req_mis, req_oor, req_fault, ld_oor, accept;

    // Decode fetch and load addresses; range compare is full width so
    // large addresses never alias onto low words.
    always_comb begin
        req_idx   = bus.req_addr >> OFF;
        ld_idx    = bus.ld_addr  >> OFF;
        req_mis   = |(bus.req_addr & OFF_MASK);
        req_oor   = {1'b0, req_idx} >= DEPTH_EXT;
        ld_oor    = {1'b0, ld_idx}  >= DEPTH_EXT;
        req_fault = req_mis || req_oor;
    end

    // A single output register: a new request fits whenever the held one
    // is empty or leaves this cycle, so streaming has no bubbles.
    assign bus.req_ready  = !resp_valid_q || bus.resp_ready;
    assign accept         = bus.req_valid && bus.req_ready;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_instr = resp_instr_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.err_count  = err_count_q;

    // Program download; out-of-range loads are dropped.
    always_ff @(posedge clk) begin
        if (bus.ld_en && !ld_oor) begin
            mem_q[ld_idx[IDX_W-1:0]] <= bus.ld_data;
        end
    end

    // Next state of the output stage and the fault counter.
    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_instr_d = resp_instr_q;
        resp_err_d   = resp_err_q;
        err_count_d  = err_count_q;
        if (accept) begin
            resp_valid_d = 1'b1;
            resp_err_d   = {req_oor, req_mis};
            // mem_q here is the pre-edge value, so a same-edge load to this
            // word is not seen by this fetch (read-first).
            resp_instr_d = req_fault ? NOP_INSTR : mem_q[req_idx[IDX_W-1:0]];
            if (req_fault && (err_count_q != 16'hFFFF)) begin
                err_count_d = err_count_q + 16'd1;
            end
        end else if (bus.resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    // Output register and counter; async reset drops any pending response.
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            resp_instr_q <= NOP_INSTR;
            resp_err_q   <= 2'b00;
            err_count_q  <= 16'd0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_instr_q <= resp_instr_d;
            resp_err_q   <= resp_err_d;
            err_count_q  <= err_count_d;
        end
    end
endmodule

// File: tb/tb_instr_mem_pipe.sv
// Directed bench for instr_mem_pipe with a scoreboard queue: expectations
// are pushed when a request is accepted and popped on each response
// handshake. Outputs are sampled on the falling clock edge.
module tb_instr_mem_pipe;
    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct packed {
        logic [31:0] instr;
        logic [1:0]  err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_mem_pipe_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    instr_mem_pipe #(
        .DATA_W(32), .DEPTH(256), .ADDR_W(32), .NOP_INSTR(NOP), .INIT_FILE("")
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    exp_t        sb[$];
    logic [31:0] model [256];
    logic [15:0] exp_errs = 16'd0;
    int          n_chk  = 0;
    int          n_pass = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes mid-cycle, update scoreboard and model,
    // then return just after the next rising edge for new stimulus.
    task automatic cycle();
        exp_t        e;
        logic [31:0] a;
        logic        mis, oor;
        @(negedge clk);
        if (bus.resp_valid && bus.resp_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_resp", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("resp_instr", 64'(bus.resp_instr), 64'(e.instr));
                chk("resp_err",   64'(bus.resp_err),   64'(e.err));
            end
        end
        if (bus.req_valid && bus.req_ready) begin
            a   = bus.req_addr;
            mis = (a[1:0] != 2'b00);
            oor = ((a >> 2) >= 32'd256);
            e.err   = {oor, mis};
            e.instr = (mis || oor) ? NOP : model[a[9:2]];
            sb.push_back(e);
            if ((mis || oor) && exp_errs != 16'hFFFF) exp_errs = exp_errs + 16'd1;
        end
        if (bus.ld_en) begin
            a = bus.ld_addr;
            if ((a >> 2) < 32'd256) model[a[9:2]] = bus.ld_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] addr, input logic [31:0] data);
        bus.ld_en   = 1'b1;
        bus.ld_addr = addr;
        bus.ld_data = data;
        cycle();
        bus.ld_en   = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] addr);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        cycle();
        bus.req_valid = 1'b0;
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.resp_ready = 1'b1;
        bus.ld_en      = 1'b0;
        bus.ld_addr    = '0;
        bus.ld_data    = '0;

        // Power-on reset
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_resp_instr", 64'(bus.resp_instr), 64'(NOP));
        chk("rst_resp_err",   64'(bus.resp_err),   64'd0);
        chk("rst_err_count",  64'(bus.err_count),  64'd0);
        chk("rst_req_ready",  64'(bus.req_ready),  64'd1);

        // Program download and streaming fetch
        load(32'd0,  32'h11);
        load(32'd4,  32'h22);
        load(32'd8,  32'h33);
        load(32'd12, 32'h44);
        for (int i = 0; i < 4; i++) begin
            bus.req_valid = 1'b1;
            bus.req_addr  = 32'(i * 4);
            cycle();
            chk("stream_valid", 64'(bus.resp_valid), 64'd1);
        end
        bus.req_valid = 1'b0;
        cycle();
        chk("stream_idle_valid", 64'(bus.resp_valid), 64'd0);
        chk("stream_drained",    64'(sb.size()),      64'd0);

        // Backpressure, with a load to the held word during the stall
        fetch(32'd4);
        bus.req_valid  = 1'b1;
        bus.req_addr   = 32'd8;
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.ld_en   = (i == 1);
            bus.ld_addr = 32'd4;
            bus.ld_data = 32'h55;
            #1;
            chk("stall_req_ready", 64'(bus.req_ready),  64'd0);
            chk("stall_valid",     64'(bus.resp_valid), 64'd1);
            chk("stall_instr",     64'(bus.resp_instr), 64'h22);
            cycle();
        end
        bus.ld_en      = 1'b0;
        bus.resp_ready = 1'b1;
        cycle();
        bus.req_valid = 1'b0;
        chk("release_valid", 64'(bus.resp_valid), 64'd1);
        cycle();
        chk("release_drained", 64'(sb.size()), 64'd0);

        // Out-of-range load must not alias onto word 0
        load(32'd1024, 32'hDEAD);
        fetch(32'd0);
        cycle();

        // Reset mid-transfer drops the pending response
        bus.resp_ready = 1'b0;
        fetch(32'd2);
        chk("pre_rst_valid",     64'(bus.resp_valid), 64'd1);
        chk("pre_rst_err_count", 64'(bus.err_count),  64'(exp_errs));
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid",     64'(bus.resp_valid), 64'd0);
        chk("mid_rst_instr",     64'(bus.resp_instr), 64'(NOP));
        chk("mid_rst_err_count", 64'(bus.err_count),  64'd0);
        sb.delete();
        exp_errs = 16'd0;
        bus.resp_ready = 1'b1;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_valid", 64'(bus.resp_valid), 64'd0);

        // Faulting fetches
        fetch(32'd94);
        fetch(32'd1024);
        fetch(32'd1026);
        cycle();
        chk("fault_err_count", 64'(bus.err_count), 64'd3);
        chk("fault_drained",   64'(sb.size()),     64'd0);

        // Same-edge load and fetch of one word: read-first, then new value
        bus.ld_en   = 1'b1;
        bus.ld_addr = 32'd8;
        bus.ld_data = 32'hAA;
        fetch(32'd8);
        bus.ld_en = 1'b0;
        fetch(32'd8);
        cycle();
        chk("rf_drained", 64'(sb.size()), 64'd0);

        // Saturating fault counter
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'd1024;
        repeat (65537) cycle();
        bus.req_valid = 1'b0;
        repeat (2) cycle();
        chk("sat_err_count", 64'(bus.err_count), 64'hFFFF);
        chk("sat_drained",   64'(sb.size()),     64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
